// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot snapshot,
// hex decode, decimal points, blanking, 16-level PWM brightness and a dark guard interval.
module seg_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000,
    parameter int GUARD  = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [3:0]            bright,
    output logic [7:0]            SEG,
    output logic [7:0]            AN,
    output logic                  frame_tick
);

    localparam int SLICE = DIV / 16;
    localparam int CNT_W = $clog2(DIV);
    localparam int SUB_W = $clog2(SLICE);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SLICE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Active-low glyph for a hex nibble; bit 0 carries the decimal point.
    function automatic logic [7:0] seg_code(input logic [3:0] nib, input logic dp_on);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'h03;
            4'h1: g = 8'h9F;
            4'h2: g = 8'h25;
            4'h3: g = 8'h0D;
            4'h4: g = 8'h99;
            4'h5: g = 8'h49;
            4'h6: g = 8'h41;
            4'h7: g = 8'h1F;
            4'h8: g = 8'h01;
            4'h9: g = 8'h09;
            4'hA: g = 8'h11;
            4'hB: g = 8'hC1;
            4'hC: g = 8'h63;
            4'hD: g = 8'h85;
            4'hE: g = 8'h61;
            default: g = 8'h71;
        endcase
        return {g[7:1], ~dp_on};
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [SUB_W-1:0] sub;
    logic [3:0]       phase;
    logic [IDX_W-1:0] idx;

    logic [3:0] nib_snap;
    logic       dp_snap;
    logic       blank_snap;
    logic [3:0] bright_snap;

    // Phase is tracked with a sub-slice counter instead of dividing cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sub   <= '0;
            phase <= '0;
            idx   <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            sub   <= '0;
            phase <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (sub == SUB_LAST) begin
                sub   <= '0;
                phase <= phase + 4'd1;
            end else begin
                sub <= sub + SUB_W'(1);
            end
        end
    end

    // Stage p0: slot-effective settings; at cnt==0 the live inputs are the snapshot.
    logic       start_p0;
    logic [3:0] nib_p0;
    logic       dp_p0;
    logic       blank_p0;
    logic [3:0] bright_p0;
    logic       lit_p0;

    always_comb begin
        start_p0  = (cnt == '0);
        nib_p0    = start_p0 ? data[{idx, 2'b00} +: 4] : nib_snap;
        dp_p0     = start_p0 ? dp[idx]                 : dp_snap;
        blank_p0  = start_p0 ? blank[idx]              : blank_snap;
        bright_p0 = start_p0 ? bright                  : bright_snap;
        lit_p0    = en && !blank_p0 && (cnt >= GUARD_C) && (phase <= bright_p0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_snap    <= '0;
            dp_snap     <= 1'b0;
            blank_snap  <= 1'b0;
            bright_snap <= '0;
        end else if (start_p0) begin
            nib_snap    <= nib_p0;
            dp_snap     <= dp_p0;
            blank_snap  <= blank_p0;
            bright_snap <= bright_p0;
        end
    end

    // Stage p1: registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AN         <= 8'hFF;
            SEG        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            AN         <= lit_p0 ? ~(8'd1 << idx) : 8'hFF;
            SEG        <= lit_p0 ? seg_code(nib_p0, dp_p0) : 8'hFF;
            frame_tick <= (idx == IDX_LAST) && (cnt == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus randomized stimulus
// compared cycle by cycle against a time-index reference model.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 64;
    localparam int GUARD  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  bright = '0;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] GLYPH [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data(data), .dp(dp), .blank(blank),
        .bright(bright), .SEG(SEG), .AN(AN), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference: m_t counts edges since reset; digit and slot position follow by division.
    int         m_t;
    logic [3:0] s_nib, s_br;
    logic       s_dp, s_blk;
    logic [7:0] exp_an, exp_seg;
    logic       exp_ft;

    always @(posedge clk or negedge rst_n) begin : model
        automatic int c, d;
        automatic logic [3:0] nib, br;
        automatic logic dpb, blk, lit;
        if (!rst_n) begin
            m_t <= 0;
            s_nib <= '0; s_br <= '0; s_dp <= 1'b0; s_blk <= 1'b0;
            exp_an <= 8'hFF; exp_seg <= 8'hFF; exp_ft <= 1'b0;
        end else begin
            c = m_t % DIV;
            d = (m_t / DIV) % DIGITS;
            if (c == 0) begin
                nib = data[4*d +: 4]; dpb = dp[d]; blk = blank[d]; br = bright;
            end else begin
                nib = s_nib; dpb = s_dp; blk = s_blk; br = s_br;
            end
            lit = en && !blk && (c >= GUARD) && ((c / (DIV / 16)) <= int'(br));
            s_nib <= nib; s_dp <= dpb; s_blk <= blk; s_br <= br;
            exp_an  <= lit ? ~(8'h01 << d) : 8'hFF;
            exp_seg <= lit ? {GLYPH[nib][7:1], ~dpb} : 8'hFF;
            exp_ft  <= (d == DIGITS - 1) && (c == DIV - 1);
            m_t <= m_t + 1;
        end
    end

    task automatic align(input int pos);
        int k;
        k = 0;
        while ((m_t % FRAME) != pos && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if ((m_t % FRAME) != pos) begin
            n_errors++;
            $display("FAIL align: position %0d, wanted %0d", m_t % FRAME, pos);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b1; bright = 4'd15; data = 16'h3210; dp = '0; blank = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (AN !== 8'hFF) begin n_errors++; $display("FAIL reset_an: got %h want ff", AN); end
        n_checks++;
        if (SEG !== 8'hFF) begin n_errors++; $display("FAIL reset_seg: got %h want ff", SEG); end
        n_checks++;
        if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL reset_ft: got %b want 0", frame_tick); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_scan();
        int lit [DIGITS];
        int ticks, first_tick;
        logic [7:0] sel;
        logic [7:0] want [DIGITS] = '{8'h03, 8'h9F, 8'h25, 8'h0D};
        for (int d = 0; d < DIGITS; d++) lit[d] = 0;
        ticks = 0; first_tick = -1;
        align(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg || frame_tick !== exp_ft) begin
                n_errors++;
                $display("FAIL scan_model i=%0d AN=%h/%h SEG=%h/%h ft=%b/%b", i, AN, exp_an, SEG, exp_seg, frame_tick, exp_ft);
            end
            for (int d = 0; d < DIGITS; d++) begin
                sel = 8'h01 << d;
                if (AN === ~sel) begin
                    lit[d]++;
                    n_checks++;
                    if (SEG !== want[d]) begin
                        n_errors++;
                        $display("FAIL scan_seg d=%0d got %h want %h", d, SEG, want[d]);
                    end
                end
            end
            if (frame_tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
            @(negedge clk);
        end
        for (int d = 0; d < DIGITS; d++) begin
            n_checks++;
            if (lit[d] != 2 * (DIV - GUARD)) begin
                n_errors++;
                $display("FAIL scan_lit d=%0d got %0d want %0d", d, lit[d], 2 * (DIV - GUARD));
            end
        end
        n_checks++;
        if (ticks != 2 || first_tick != FRAME - 1) begin
            n_errors++;
            $display("FAIL scan_tick count=%0d first=%0d want 2 and %0d", ticks, first_tick, FRAME - 1);
        end
    endtask

    task automatic test_bright(input logic [3:0] b);
        int lit [DIGITS];
        int want;
        logic [7:0] sel;
        for (int d = 0; d < DIGITS; d++) lit[d] = 0;
        want = (int'(b) + 1) * DIV / 16 - GUARD;
        align(0);
        bright = b;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg || frame_tick !== exp_ft) begin
                n_errors++;
                $display("FAIL bright_model b=%0d i=%0d AN=%h/%h SEG=%h/%h", b, i, AN, exp_an, SEG, exp_seg);
            end
            for (int d = 0; d < DIGITS; d++) begin
                sel = 8'h01 << d;
                if (AN === ~sel) lit[d]++;
            end
            @(negedge clk);
        end
        for (int d = 0; d < DIGITS; d++) begin
            n_checks++;
            if (lit[d] != want) begin
                n_errors++;
                $display("FAIL bright_lit b=%0d d=%0d got %0d want %0d", b, d, lit[d], want);
            end
        end
        bright = 4'd15;
    endtask

    task automatic test_blank_dp();
        int lit2;
        lit2 = 0;
        align(0);
        blank = 4'b0100; dp = 4'b0001;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg) begin
                n_errors++;
                $display("FAIL blank_model i=%0d AN=%h/%h SEG=%h/%h", i, AN, exp_an, SEG, exp_seg);
            end
            if (AN === 8'hFB) lit2++;
            if (i >= 2 * DIV && i < 3 * DIV) begin
                n_checks++;
                if (AN !== 8'hFF || SEG !== 8'hFF) begin
                    n_errors++;
                    $display("FAIL blank_dark i=%0d AN=%h SEG=%h want ff ff", i, AN, SEG);
                end
            end
            if (AN === 8'hFE) begin
                n_checks++;
                if (SEG !== 8'h02) begin
                    n_errors++;
                    $display("FAIL dp_seg got %h want 02", SEG);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (lit2 != 0) begin n_errors++; $display("FAIL blank_lit got %0d want 0", lit2); end
        blank = '0; dp = '0;
    endtask

    task automatic test_midslot_data();
        data = 16'h3210;
        align(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 10) data[3:0] = 4'h8;
            @(posedge clk); #1;
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg) begin
                n_errors++;
                $display("FAIL mid_model i=%0d AN=%h/%h SEG=%h/%h", i, AN, exp_an, SEG, exp_seg);
            end
            if (AN === 8'hFE) begin
                n_checks++;
                if (SEG !== ((i < FRAME) ? 8'h03 : 8'h01)) begin
                    n_errors++;
                    $display("FAIL mid_seg i=%0d got %h want %h", i, SEG, (i < FRAME) ? 8'h03 : 8'h01);
                end
            end
            @(negedge clk);
        end
        data = 16'h3210;
    endtask

    task automatic test_en_gap();
        int ticks [$];
        align(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 100) en = 1'b0;
            if (i == 105) en = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg || frame_tick !== exp_ft) begin
                n_errors++;
                $display("FAIL en_model i=%0d AN=%h/%h SEG=%h/%h", i, AN, exp_an, SEG, exp_seg);
            end
            if (i >= 100 && i < 105) begin
                n_checks++;
                if (AN !== 8'hFF || SEG !== 8'hFF) begin
                    n_errors++;
                    $display("FAIL en_dark i=%0d AN=%h SEG=%h want ff ff", i, AN, SEG);
                end
            end
            if (i == 106) begin
                n_checks++;
                if (AN !== 8'hFD) begin n_errors++; $display("FAIL en_resume got %h want fd", AN); end
            end
            if (frame_tick === 1'b1) ticks.push_back(i);
            @(negedge clk);
        end
        n_checks++;
        if (ticks.size() != 2 || ticks[0] != FRAME - 1 || ticks[1] - ticks[0] != FRAME) begin
            n_errors++;
            $display("FAIL en_tick count=%0d want 2 ticks %0d apart", ticks.size(), FRAME);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)  data   = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp     = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank  = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bright = 4'($urandom);
            if ($urandom_range(0, 19) == 0) en     = ~en;
            @(posedge clk); #1;
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg || frame_tick !== exp_ft) begin
                n_errors++;
                $display("FAIL rand_model i=%0d AN=%h/%h SEG=%h/%h ft=%b/%b", i, AN, exp_an, SEG, exp_seg, frame_tick, exp_ft);
            end
            if ($countones(~AN) > 1) begin
                n_errors++;
                $display("FAIL rand_onehot AN=%h", AN);
            end
            @(negedge clk);
        end
        en = 1'b1; dp = '0; blank = '0; bright = 4'd15; data = 16'h3210;
    endtask

    task automatic test_reset_mid();
        int first_tick;
        first_tick = -1;
        align(2 * DIV + 40);
        n_checks++;
        if (AN !== 8'hFB) begin n_errors++; $display("FAIL rmid_pre got %h want fb", AN); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (AN !== 8'hFF || SEG !== 8'hFF) begin
            n_errors++;
            $display("FAIL rmid_async AN=%h SEG=%h want ff ff", AN, SEG);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME + 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (AN !== exp_an || SEG !== exp_seg || frame_tick !== exp_ft) begin
                n_errors++;
                $display("FAIL rmid_model i=%0d AN=%h/%h SEG=%h/%h", i, AN, exp_an, SEG, exp_seg);
            end
            if (i == 10) begin
                n_checks++;
                if (AN !== 8'hFE) begin n_errors++; $display("FAIL rmid_digit0 got %h want fe", AN); end
            end
            if (frame_tick === 1'b1 && first_tick < 0) first_tick = i;
            @(negedge clk);
        end
        n_checks++;
        if (first_tick != FRAME - 1) begin
            n_errors++;
            $display("FAIL rmid_tick first=%0d want %0d", first_tick, FRAME - 1);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_bright(4'd7);
        test_bright(4'd0);
        test_blank_dp();
        test_midslot_data();
        test_en_gap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
